// File: rtl/bw_clk_cclk_hdr_ctl.sv
`default_nettype none
// ============================================================================
// Module      : bw_clk_cclk_hdr_ctl
// Description : Cluster-header clock controller at the receive end of the
//               global clock tree. It runs on the arriving gclk and does four
//               things:
//                 - synchronises the asynchronous cluster clock-enable
//                   request (cken_req),
//                 - sequences the header gating cell on and off, with
//                   programmable settle (start) and drain (stop) delays,
//                 - supports debug clock-stretch pulses,
//                 - returns a settled acknowledge (cken_ack) to the clock
//                   controller.
//
// Ports       : gclk        - global clock as received at the cluster
//               grst        - asynchronous active-high reset
//               cken_req    - async cluster clock-enable request
//               start_dly   - settle cycles before enabling (quasi-static)
//               stop_dly    - drain cycles before disabling (quasi-static)
//               stretch_req - gclk-synchronous single-cycle stretch request
//               stretch_len - cycles clk_en is held low per stretch
//               clk_en      - enable to header gating cell (dedicated flop)
//               cken_ack    - settled acknowledge of cken_req
//               state_o     - FSM state (OFF=0 START=1 ON=2 STOP=3 STRETCH=4)
//               busy        - high while in START, STOP or STRETCH
//
// Revision    : 1.0 - initial release
// ============================================================================
module bw_clk_cclk_hdr_ctl #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             gclk,
    input  logic             grst,
    input  logic             cken_req,
    input  logic [CNT_W-1:0] start_dly,
    input  logic [CNT_W-1:0] stop_dly,
    input  logic             stretch_req,
    input  logic [CNT_W-1:0] stretch_len,
    output logic             clk_en,
    output logic             cken_ack,
    output logic [2:0]       state_o,
    output logic             busy
);

    // A single-flop synchroniser is never acceptable for cken_req.
    // Smaller settings are therefore raised to two stages.
    localparam int c_sync_n = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_START   = 3'd1,
        ST_ON      = 3'd2,
        ST_STOP    = 3'd3,
        ST_STRETCH = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_clk_en;
    logic               w_clk_en_nxt;
    logic               r_ack;
    logic               w_ack_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic [c_sync_n-1:0] r_sync;
    logic               w_req_s;
    logic               w_cnt_zero;

    // ------------------------------------------------------------------
    // cken_req synchroniser. This is the only logic that samples the raw
    // request; everything downstream uses w_req_s.
    // ------------------------------------------------------------------
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_sync_n-2:0], cken_req};
        end
    end

    assign w_req_s    = r_sync[c_sync_n-1];
    assign w_cnt_zero = (r_cnt == '0);

    // ------------------------------------------------------------------
    // State, counter and output registers. clk_en comes straight from a
    // flop so the gating cell never sees a decode glitch.
    // ------------------------------------------------------------------
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_state  <= ST_OFF;
            r_cnt    <= '0;
            r_clk_en <= 1'b0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_clk_en <= w_clk_en_nxt;
            r_ack    <= w_ack_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. The counter is loaded only when a
    // state is entered. It then counts down to zero in that state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_clk_en_nxt = r_clk_en;
        w_ack_nxt    = r_ack;

        case (r_state)
            ST_OFF: begin
                w_clk_en_nxt = 1'b0;
                w_ack_nxt    = 1'b0;
                if (w_req_s) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = start_dly;
                end
            end

            ST_START: begin
                w_clk_en_nxt = 1'b0;
                if (!w_req_s) begin
                    // Request withdrawn before settling.
                    // Abort without ever enabling the clock.
                    w_state_nxt = ST_OFF;
                end else if (w_cnt_zero) begin
                    w_state_nxt  = ST_ON;
                    w_clk_en_nxt = 1'b1;
                    w_ack_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            ST_ON: begin
                w_clk_en_nxt = 1'b1;
                w_ack_nxt    = 1'b1;
                // A disable request wins over a simultaneous stretch.
                // That stretch is dropped, not queued.
                if (!w_req_s) begin
                    w_state_nxt = ST_STOP;
                    w_cnt_nxt   = stop_dly;
                end else if (stretch_req && (stretch_len != '0)) begin
                    w_state_nxt  = ST_STRETCH;
                    w_cnt_nxt    = stretch_len - CNT_W'(1);
                    w_clk_en_nxt = 1'b0;
                end
            end

            ST_STOP: begin
                // Clock stays on while the pipeline drains. A returning
                // request is not looked at here. OFF will pick it up.
                if (w_cnt_zero) begin
                    w_state_nxt  = ST_OFF;
                    w_clk_en_nxt = 1'b0;
                    w_ack_nxt    = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            ST_STRETCH: begin
                // The counter was loaded with len-1, and the exit edge
                // itself is one low cycle. Together that gives exactly
                // stretch_len low cycles. A falling request waits in the
                // synchroniser until ON.
                if (w_cnt_zero) begin
                    w_state_nxt  = ST_ON;
                    w_clk_en_nxt = 1'b1;
                end else begin
                    w_clk_en_nxt = 1'b0;
                    w_cnt_nxt    = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                // Unused encodings fall back to a safe, gated-off state.
                w_state_nxt  = ST_OFF;
                w_cnt_nxt    = '0;
                w_clk_en_nxt = 1'b0;
                w_ack_nxt    = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_START) ||
                     (w_state_nxt == ST_STOP)  ||
                     (w_state_nxt == ST_STRETCH);
    end

    assign clk_en   = r_clk_en;
    assign cken_ack = r_ack;
    assign state_o  = r_state;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bw_clk_cclk_hdr_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bw_clk_cclk_hdr_ctl
// Description : Directed self-checking bench for bw_clk_cclk_hdr_ctl.
//               Expected values are hand-derived edge counts. Inputs change
//               and outputs are sampled 1 ns after each rising gclk edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bw_clk_cclk_hdr_ctl;

    localparam int c_cnt_w = 4;

    logic               gclk = 1'b0;
    logic               grst;
    logic               cken_req;
    logic [c_cnt_w-1:0] start_dly;
    logic [c_cnt_w-1:0] stop_dly;
    logic               stretch_req;
    logic [c_cnt_w-1:0] stretch_len;
    logic               clk_en;
    logic               cken_ack;
    logic [2:0]         state_o;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    always #5 gclk = ~gclk;

    bw_clk_cclk_hdr_ctl #(
        .SYNC_STAGES (2),
        .CNT_W       (c_cnt_w)
    ) dut (
        .gclk        (gclk),
        .grst        (grst),
        .cken_req    (cken_req),
        .start_dly   (start_dly),
        .stop_dly    (stop_dly),
        .stretch_req (stretch_req),
        .stretch_len (stretch_len),
        .clk_en      (clk_en),
        .cken_ack    (cken_ack),
        .state_o     (state_o),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic test_reset();
        grst = 1'b1; cken_req = 1'b0; start_dly = '0; stop_dly = '0;
        stretch_req = 1'b0; stretch_len = '0;
        tick(); tick();
        checks++;
        if ({clk_en, cken_ack, state_o, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset: clk_en=%b ack=%b state=%0d busy=%b, want all 0",
                     clk_en, cken_ack, state_o, busy);
        end
        grst = 1'b0;
        tick();
    endtask

    // Edge k after cken_req rises: START from k=3, ON (clk_en, ack) at k=7.
    task automatic test_enable();
        logic [2:0] e_state;
        start_dly = 4'd3;
        cken_req  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            e_state = (k <= 2) ? 3'd0 : (k <= 6) ? 3'd1 : 3'd2;
            checks++;
            if (state_o !== e_state || clk_en !== (k == 7) ||
                cken_ack !== (k == 7) || busy !== (k >= 3 && k <= 6)) begin
                failures++;
                $display("FAIL enable k=%0d: state=%0d en=%b ack=%b busy=%b, want state=%0d en=%b ack=%b busy=%b",
                         k, state_o, clk_en, cken_ack, busy, e_state,
                         (k == 7), (k == 7), (k >= 3 && k <= 6));
            end
        end
    endtask

    // Pulse seen at edge 1: clk_en low after edges 1..4, back high at edge 5.
    task automatic test_stretch();
        logic e_low;
        stretch_len = 4'd4;
        stretch_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            stretch_req = 1'b0;
            e_low = (k <= 4);
            checks++;
            if (clk_en !== !e_low || cken_ack !== 1'b1 || busy !== e_low ||
                state_o !== (e_low ? 3'd4 : 3'd2)) begin
                failures++;
                $display("FAIL stretch k=%0d: state=%0d en=%b ack=%b busy=%b, want state=%0d en=%b ack=1 busy=%b",
                         k, state_o, clk_en, cken_ack, busy,
                         (e_low ? 3'd4 : 3'd2), !e_low, e_low);
            end
        end
    endtask

    task automatic test_stretch_zero();
        stretch_len = 4'd0;
        stretch_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            stretch_req = 1'b0;
            checks++;
            if ({clk_en, cken_ack, state_o, busy} !== {1'b1, 1'b1, 3'd2, 1'b0}) begin
                failures++;
                $display("FAIL stretch_zero k=%0d: state=%0d en=%b ack=%b busy=%b, want state=2 en=1 ack=1 busy=0",
                         k, state_o, clk_en, cken_ack, busy);
            end
        end
    endtask

    // STOP from edge 3, OFF at edge 6.
    // A stretch pulse on the ON->STOP edge must be dropped.
    task automatic test_disable();
        logic [2:0] e_state;
        stop_dly    = 4'd2;
        stretch_len = 4'd4;
        cken_req    = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            stretch_req = (k == 2);
            e_state = (k <= 2) ? 3'd2 : (k <= 5) ? 3'd3 : 3'd0;
            checks++;
            if (state_o !== e_state || clk_en !== (k < 6) ||
                cken_ack !== (k < 6) || busy !== (k >= 3 && k <= 5)) begin
                failures++;
                $display("FAIL disable k=%0d: state=%0d en=%b ack=%b busy=%b, want state=%0d en=%b ack=%b busy=%b",
                         k, state_o, clk_en, cken_ack, busy, e_state,
                         (k < 6), (k < 6), (k >= 3 && k <= 5));
            end
        end
        stretch_req = 1'b0;
    endtask

    task automatic test_abort();
        start_dly = 4'd15;
        cken_req  = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        checks++;
        if (state_o !== 3'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_start: state=%0d busy=%b, want state=1 busy=1",
                     state_o, busy);
        end
        cken_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (clk_en !== 1'b0 || cken_ack !== 1'b0) begin
                failures++;
                $display("FAIL abort_en k=%0d: en=%b ack=%b, want 0 0",
                         k, clk_en, cken_ack);
            end
        end
        checks++;
        if (state_o !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_off: state=%0d busy=%b, want state=0 busy=0",
                     state_o, busy);
        end
    endtask

    task automatic test_async_reset();
        start_dly = 4'd3;
        cken_req  = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        stretch_len = 4'd4;
        stretch_req = 1'b1;
        tick();
        stretch_req = 1'b0;
        tick();
        checks++;
        if (state_o !== 3'd4 || clk_en !== 1'b0) begin
            failures++;
            $display("FAIL areset_pre: state=%0d en=%b, want state=4 en=0",
                     state_o, clk_en);
        end
        // Assert reset between edges and look before the next edge.
        #3;
        grst = 1'b1;
        #1;
        checks++;
        if ({clk_en, cken_ack, state_o, busy} !== 6'b0) begin
            failures++;
            $display("FAIL areset_now: en=%b ack=%b state=%0d busy=%b, want all 0",
                     clk_en, cken_ack, state_o, busy);
        end
        tick();
        grst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (clk_en !== (k == 7) || cken_ack !== (k == 7)) begin
                failures++;
                $display("FAIL areset_relat k=%0d: en=%b ack=%b, want %b %b",
                         k, clk_en, cken_ack, (k == 7), (k == 7));
            end
        end
    endtask

    // Request drops at edge 0 and returns after edge 4.
    // STOP runs edges 3..8, OFF at 9, START 10..12, ON at 13.
    task automatic test_rerequest();
        logic [2:0] e_state;
        logic       e_en;
        stop_dly  = 4'd5;
        start_dly = 4'd2;
        cken_req  = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 4) cken_req = 1'b1;
            e_state = (k <= 2) ? 3'd2 : (k <= 8) ? 3'd3 :
                      (k == 9) ? 3'd0 : (k <= 12) ? 3'd1 : 3'd2;
            e_en = (k <= 8) || (k == 13);
            checks++;
            if (state_o !== e_state || clk_en !== e_en || cken_ack !== e_en) begin
                failures++;
                $display("FAIL rereq k=%0d: state=%0d en=%b ack=%b, want state=%0d en=%b ack=%b",
                         k, state_o, clk_en, cken_ack, e_state, e_en, e_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_stretch();
        test_stretch_zero();
        test_disable();
        test_abort();
        test_async_reset();
        test_rerequest();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
